// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: signal bundle between the byte FIFO read side, the enable
// control and the UART transmit stage.
//
//   tx_en       - permission to start a new frame (sampled only while idle)
//   fifo_empty  - FIFO empty flag (sampled only while idle)
//   fifo_data   - FIFO registered read data
//   fifo_rd_en  - FIFO read strobe
//   tx          - serial line, idles high
//   busy        - transmitter is anywhere other than idle
//   tx_done     - one-cycle pulse in the last cycle of the final stop bit
//
// Read handshake: the transmitter raises fifo_rd_en for exactly one cycle,
// and only when it saw fifo_empty low while idle. The FIFO must present the
// byte on fifo_data in the following cycle, which is when it is captured.
// There is no back-pressure: a strobe is never issued unless the FIFO has
// already advertised data, so every strobe consumes exactly one byte.
//
// master: drives tx_en / fifo_empty / fifo_data (FIFO + control side).
// slave : drives fifo_rd_en / tx / busy / tx_done (the transmitter).
`timescale 1ns/1ps
interface fifo_uart_tx_if;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    output tx_en, fifo_empty, fifo_data,
    input  fifo_rd_en, tx, busy, tx_done
  );

  modport slave (
    input  tx_en, fifo_empty, fifo_data,
    output fifo_rd_en, tx, busy, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous byte FIFO one byte at a time and sends
// each byte as a UART frame: start bit, 8 data bits LSB first, optional
// parity bit, 1 or 2 stop bits. A new byte is only requested from IDLE, so
// no read is ever issued while a frame is on the line.
//
// Ports:
//   clk        - rising-edge clock (shared with the FIFO)
//   rst        - asynchronous, active-low reset
//   bus        - fifo_uart_tx_if.slave (tx_en, fifo_empty, fifo_data in;
//                fifo_rd_en, tx, busy, tx_done out)
//   dbg_state  - current FSM state encoding, for observation only
//
// Every output is decoded from registered state (FSM, baud counter, stop
// index, shift register, parity flop); no input reaches an output
// combinationally.
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  fifo_uart_tx_if.slave    bus,
  output logic [2:0]       dbg_state
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);
  // stop_idx value during the final stop bit
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LATCH  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          parity_bit;
  logic          stop_idx;

  logic          bit_end;
  logic          timed;
  logic          tx_c;
  logic          rd_en_c;
  logic          busy_c;
  logic          done_c;

  assign bit_end = (baud_cnt == TERM);
  // States that hold the line for whole bit periods.
  assign timed   = (state == START) || (state == DATA) ||
                   (state == PARITY) || (state == STOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_c       = 1'b1;
    rd_en_c    = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.tx_en && !bus.fifo_empty) state_next = FETCH;
      end
      FETCH: begin
        rd_en_c    = 1'b1;
        state_next = LATCH;
      end
      LATCH: state_next = START;
      START: begin
        tx_c = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx_c = shift[0];
        if (bit_end && bit_idx == 3'd7)
          state_next = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        tx_c = parity_bit;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end && stop_idx == STOP_LAST) begin
          done_c     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      stop_idx   <= 1'b0;
    end else begin
      // Restart the bit period on every state change and bit boundary so the
      // counter never runs past TERM; it rests at zero outside timed states.
      if (state_next != state || bit_end || !timed) baud_cnt <= '0;
      else                                          baud_cnt <= baud_cnt + CW'(1);

      case (state)
        LATCH: begin
          shift      <= bus.fifo_data;
          parity_bit <= (^bus.fifo_data) ^ (PARITY_ODD != 0);
          bit_idx    <= '0;
          stop_idx   <= 1'b0;
        end
        DATA: begin
          if (bit_end) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (bit_end) stop_idx <= ~stop_idx;
        end
        default: ;
      endcase
    end
  end

  assign bus.tx         = tx_c;
  assign bus.fifo_rd_en = rd_en_c;
  assign bus.busy       = busy_c;
  assign bus.tx_done    = done_c;
  assign dbg_state      = state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three transmitters at CLKS_PER_BIT=4
//   u[0]: no parity, 1 stop   u[1]: even parity, 2 stop   u[2]: odd parity, 2 stop
// Each has a FIFO model with 1-cycle read latency, an expected-frame queue
// filled when bytes are loaded, and a frame monitor that pops and compares.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
  localparam int W   = 12;
  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pe_of(input int g); return (g == 0) ? 0 : 1; endfunction
  function automatic int po_of(input int g); return (g == 2) ? 1 : 0; endfunction
  function automatic int sb_of(input int g); return (g == 0) ? 1 : 2; endfunction

  // Expected line levels, one per bit period, bit 0 = start bit.
  function automatic logic [W-1:0] build_frame(input logic [7:0] b, input int pe,
                                                input int po, input int sb);
    logic [W-1:0] f;
    int n;
    f      = '0;
    f[8:1] = b;
    n      = 9;
    if (pe != 0) begin
      f[9] = (^b) ^ (po != 0);
      n    = 10;
    end
    f[n] = 1'b1;
    if (sb == 2) f[n+1] = 1'b1;
    return f;
  endfunction

  // ---------------- DUTs, FIFO models, monitors ----------------
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int PE = pe_of(g);
    localparam int PO = po_of(g);
    localparam int SB = sb_of(g);
    localparam int NB = 10 + PE + SB - 1;

    fifo_uart_tx_if bus ();
    logic [2:0]     dbg;

    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE),
      .PARITY_ODD  (PO),
      .STOP_BITS   (SB)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_state(dbg)
    );

    logic [7:0]   fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           fetch_cyc_q[$];
    int           done_cyc_q[$];
    int           frames_done = 0;
    int           fetches     = 0;
    int           aborts      = 0;
    logic [W-1:0] last_obs;

    // FIFO model: registered read data one cycle after the strobe.
    always @(posedge clk) begin
      if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_data <= fifo_q.pop_front();
      bus.fifo_empty <= (fifo_q.size() == 0);
    end

    initial begin : mon
      logic [W-1:0] exp_f;
      logic [W-1:0] obs;
      logic         stable;
      logic         busy_ok;
      logic         done_ok;
      logic         aborted;
      int           d;
      forever begin
        @(negedge clk);
        if (rst && bus.fifo_rd_en) begin
          fetches++;
          fetch_cyc_q.push_back(cyc);
          check("fetch_expected", exp_q.size() != 0, 1);
          exp_f = '1;
          if (exp_q.size() != 0) exp_f = exp_q.pop_front();
          check("fetch_cycle", {bus.tx, bus.busy}, 2'b11);
          obs = '0; stable = 1'b1; busy_ok = 1'b1; done_ok = 1'b1; aborted = 1'b0; d = 0;
          @(negedge clk);
          if (!rst) aborted = 1'b1;
          else check("latch_cycle", {bus.tx, bus.busy, bus.fifo_rd_en}, 3'b110);
          for (int k = 0; k < NB * CPB && !aborted; k++) begin
            @(negedge clk);
            if (!rst) aborted = 1'b1;
            else begin
              if (k % CPB == 0) obs[k / CPB] = bus.tx;
              else if (bus.tx !== obs[k / CPB]) stable = 1'b0;
              if (!bus.busy || bus.fifo_rd_en) busy_ok = 1'b0;
              if (bus.tx_done !== (k == NB * CPB - 1)) done_ok = 1'b0;
              if (k == NB * CPB - 1) d = cyc;
            end
          end
          if (aborted) aborts++;
          else begin
            done_cyc_q.push_back(d);
            last_obs = obs;
            check("frame", obs, exp_f);
            check("bit_stable", stable, 1);
            check("busy_in_frame", busy_ok, 1);
            check("tx_done_pos", done_ok, 1);
            @(negedge clk);
            if (rst) check("idle_after", {bus.busy, bus.tx, dbg}, 5'b01000);
            frames_done++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int g, input logic [7:0] b);
    case (g)
      0: begin u[0].fifo_q.push_back(b); u[0].exp_q.push_back(build_frame(b, pe_of(0), po_of(0), sb_of(0))); end
      1: begin u[1].fifo_q.push_back(b); u[1].exp_q.push_back(build_frame(b, pe_of(1), po_of(1), sb_of(1))); end
      default: begin u[2].fifo_q.push_back(b); u[2].exp_q.push_back(build_frame(b, pe_of(2), po_of(2), sb_of(2))); end
    endcase
  endtask

  function automatic int frames(input int g);
    case (g)
      0: return u[0].frames_done;
      1: return u[1].frames_done;
      default: return u[2].frames_done;
    endcase
  endfunction

  function automatic int fetches(input int g);
    case (g)
      0: return u[0].fetches;
      1: return u[1].fetches;
      default: return u[2].fetches;
    endcase
  endfunction

  task automatic wait_frames(input int g, input int n, input int budget);
    int i;
    i = 0;
    while (frames(g) < n && i < budget) begin step(); i++; end
    check("wait_frames", frames(g) >= n, 1);
  endtask

  task automatic wait_fetches(input int g, input int n, input int budget);
    int i;
    i = 0;
    while (fetches(g) < n && i < budget) begin step(); i++; end
    check("wait_fetches", fetches(g) >= n, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int rel_cyc;
    int low_cnt;
    rst = 1'b0;
    u[0].bus.tx_en = 1'b1;
    u[1].bus.tx_en = 1'b1;
    u[2].bus.tx_en = 1'b1;

    // Reset held with a non-empty FIFO and tx_en high.
    load(0, 8'hA5);
    repeat (10) begin
      step();
      check("reset_out", {u[0].bus.tx, u[0].bus.fifo_rd_en, u[0].bus.busy, u[0].bus.tx_done}, 4'b1000);
    end

    // Single byte straight out of reset.
    step();
    rst = 1'b1;
    rel_cyc = cyc;
    wait_frames(0, 1, 100);
    check("fetch_after_release", u[0].fetch_cyc_q[0] - rel_cyc, 1);
    check("single_done_at", u[0].done_cyc_q[0] - u[0].fetch_cyc_q[0], 41);
    check("single_fetch_count", fetches(0), 1);

    // Back-to-back bytes: 3 idle-high cycles between stop end and start.
    load(0, 8'h00);
    load(0, 8'hFF);
    load(0, 8'h55);
    wait_frames(0, 4, 300);
    check("b2b_gap_1", u[0].fetch_cyc_q[2] - u[0].done_cyc_q[1], 2);
    check("b2b_gap_2", u[0].fetch_cyc_q[3] - u[0].done_cyc_q[2], 2);

    // Enable gating with data waiting.
    u[0].bus.tx_en = 1'b0;
    load(0, 8'h81);
    load(0, 8'h42);
    low_cnt = 0;
    repeat (100) begin
      step();
      if (!u[0].bus.tx) low_cnt++;
    end
    check("gate_no_fetch", fetches(0), 4);
    check("gate_tx_high", low_cnt, 0);

    // Drop tx_en mid-DATA: current frame completes, nothing further fetched.
    u[0].bus.tx_en = 1'b1;
    wait_fetches(0, 5, 20);
    repeat (12) step();
    u[0].bus.tx_en = 1'b0;
    wait_frames(0, 5, 100);
    low_cnt = 0;
    repeat (60) begin
      step();
      if (!u[0].bus.tx) low_cnt++;
    end
    check("drop_en_no_fetch", fetches(0), 5);
    check("drop_en_tx_high", low_cnt, 0);

    // Reset during data bit 3 of 0x42 (bit 3 is 0, so the line must jump high).
    u[0].bus.tx_en = 1'b1;
    wait_fetches(0, 6, 20);
    repeat (19) step();
    check("pre_reset_tx", u[0].bus.tx, 0);
    rst = 1'b0;
    #1;
    check("reset_tx_now", {u[0].bus.tx, u[0].bus.busy, u[0].bus.fifo_rd_en}, 3'b100);
    load(0, 8'h99);
    repeat (3) begin
      step();
      check("reset_hold", {u[0].bus.fifo_rd_en, u[0].bus.busy, u[0].bus.tx}, 3'b001);
    end
    rst = 1'b1;
    wait_frames(0, 6, 100);
    check("abort_count", u[0].aborts, 1);
    check("after_reset_byte", u[0].last_obs[8:1], 8'h99);
    check("after_reset_fetches", fetches(0), 7);

    // Parity, 2 stop bits: 0x07 gives 1 for even, 0 for odd; 48-cycle frame.
    load(1, 8'h07);
    wait_frames(1, 1, 150);
    check("par_even_bit", u[1].last_obs[9], 1);
    check("par_even_len", u[1].done_cyc_q[0] - u[1].fetch_cyc_q[0], 49);
    load(2, 8'h07);
    wait_frames(2, 1, 150);
    check("par_odd_bit", u[2].last_obs[9], 0);
    check("par_odd_len", u[2].done_cyc_q[0] - u[2].fetch_cyc_q[0], 49);
    load(1, 8'hC3);
    load(2, 8'h10);
    wait_frames(1, 2, 150);
    wait_frames(2, 2, 150);
    check("leftover_exp_0", u[0].exp_q.size(), 0);
    check("leftover_exp_1", u[1].exp_q.size(), 0);
    check("leftover_exp_2", u[2].exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 16x8 synchronous byte FIFO. It pulls one byte at a time through the FIFO read port and serialises it as an asynchronous UART frame on `tx`. The frame is one start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop bits. It paces FIFO reads so that no byte is ever requested while a frame is in flight.

## Interface
- `CLKS_PER_BIT`, default 868 — clk cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, default 0 — 1 inserts a parity bit after data bit 7.
- `PARITY_ODD`, default 0 — 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1 — number of stop bits, 1 or 2.
- `clk` input 1 — rising-edge clock, same clock as the FIFO.
- `rst` input 1 — reset, asynchronous, active-low.
- `tx_en` input 1 — permits starting a new frame; a frame already in progress always completes.
- `fifo_empty` input 1 — FIFO empty flag.
- `fifo_data` input 8 — FIFO registered read data; valid the cycle after `fifo_rd_en` is sampled high.
- `fifo_rd_en` output 1 — FIFO read strobe; exactly a one-cycle pulse per byte.
- `tx` output 1 — serial line; idle level is 1.
- `busy` output 1 — high in every state except IDLE.
- `tx_done` output 1 — one-cycle pulse in the final cycle of the last stop bit.

## Operation
- Reset values (asserted asynchronously):
  - state IDLE; `tx`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0.
  - baud counter, bit index and shift register all 0.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- States:
  - **IDLE**: `tx`=1. If `tx_en`=1 and `fifo_empty`=0, go to FETCH; otherwise stay.
  - **FETCH**: `fifo_rd_en`=1 for exactly this cycle. Always go to LATCH.
  - **LATCH**: capture `fifo_data` into the 8-bit shift register. Compute parity: XOR of the 8 bits, inverted when `PARITY_ODD`=1. Go to START.
  - **START**: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - **DATA**: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, then shift right. After bit index 7, go to PARITY if `PARITY_EN`=1, else STOP.
  - **PARITY**: `tx`=the computed parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
  - **STOP**: `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. `tx_done` pulses in the final cycle. Go to IDLE.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1 and clears on every bit boundary and on every state entry.
  - Width is clog2(`CLKS_PER_BIT`); the counter never wraps past the terminal count.
- `fifo_empty` is sampled only in IDLE. The FIFO's post-read empty update during LATCH is irrelevant to the current frame.
- A `tx_en` deassert anywhere after IDLE has no effect until the block returns to IDLE.
- Reset mid-frame: `tx` returns to 1 immediately and the byte being sent is lost. No `fifo_rd_en` is issued until after reset release.

## Timing
- Let FETCH occupy cycle T:
  - LATCH is at T+1.
  - The first START cycle is T+2.
  - Frame length is (10 + `PARITY_EN` + `STOP_BITS` - 1)×`CLKS_PER_BIT` cycles.
- Back-to-back bytes:
  - IDLE, FETCH and LATCH add exactly 3 cycles of `tx`=1 between the end of one stop period and the next start bit.
  - Sustained throughput is one byte per frame length + 3 cycles.
- The read handshake assumes a 1-cycle FIFO read latency; `fifo_data` is never sampled in the FETCH cycle itself.
- From reset release with a non-empty FIFO and `tx_en`=1: FETCH occurs in the first cycle after IDLE is sampled, which is reset release + 1.

## Test plan
- **Reset**: hold `rst`=0 with `fifo_empty`=0 and `tx_en`=1 → `tx`=1, `fifo_rd_en`=0, `busy`=0 throughout the reset.
- **Single byte**: `CLKS_PER_BIT`=4, no parity, 1 stop, FIFO holds 0xA5 →
  - exactly one `fifo_rd_en` pulse at T;
  - from T+2, `tx` = 0 followed by 1,0,1,0,0,1,0,1, then 1, each for 4 cycles;
  - `tx_done` at T+41;
  - IDLE at T+42.
- **Back-to-back**: FIFO holds 0x00, 0xFF, 0x55 → three `fifo_rd_en` pulses, each frame decoded correctly, 3 idle-high cycles between each stop end and the next start, `busy` low only in those IDLE cycles.
- **Parity**: `PARITY_EN`=1 with 0x07 → parity bit 1 when `PARITY_ODD`=0 and 0 when `PARITY_ODD`=1. With `STOP_BITS`=2, the frame is 48 cycles at `CLKS_PER_BIT`=4.
- **Enable gating**:
  - `tx_en`=0 with a non-empty FIFO for 100 cycles → no `fifo_rd_en`, `tx`=1.
  - Dropping `tx_en` during DATA → that frame completes and no further fetch occurs.
- **Reset mid-frame**: assert `rst` during DATA bit 3 →
  - `tx`=1 within the same cycle;
  - after release the next byte is fetched fresh;
  - the aborted byte is never retransmitted.
